// File: rtl/mem_refill_arbiter_if.sv
// Bus bundle between the refill arbiter, the two cache refill engines and the memory model.
// master = arbiter side, slave = caches/memory side.
interface mem_refill_arbiter_if #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4
);
   localparam int IDX_W = $clog2(LINE_WORDS);

   logic              i_IReq;
   logic [ADDR_W-1:0] i_IAddr;
   logic              i_DReq;
   logic              i_DWe;
   logic [ADDR_W-1:0] i_DAddr;
   logic [DATA_W-1:0] i_DWData;
   logic [IDX_W-1:0]  o_DWordIdx;
   logic              o_IFillValid;
   logic              o_DFillValid;
   logic [IDX_W-1:0]  o_FillIdx;
   logic [DATA_W-1:0] o_FillData;
   logic              o_IDone;
   logic              o_DDone;
   logic              o_IBusy;
   logic              o_DBusy;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  i_IReq, i_IAddr, i_DReq, i_DWe, i_DAddr, i_DWData, mem_ack, mem_rdata,
      output o_DWordIdx, o_IFillValid, o_DFillValid, o_FillIdx, o_FillData,
             o_IDone, o_DDone, o_IBusy, o_DBusy, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output i_IReq, i_IAddr, i_DReq, i_DWe, i_DAddr, i_DWData, mem_ack, mem_rdata,
      input  o_DWordIdx, o_IFillValid, o_DFillValid, o_FillIdx, o_FillData,
             o_IDone, o_DDone, o_IBusy, o_DBusy, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_refill_arbiter.sv
// Shares one main-memory port between I-cache refills and D-cache refill/write-back,
// running a fixed-length line burst over a req/ack handshake for one owner at a time.
module mem_refill_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4
) (
   input  logic                 Clk,
   input  logic                 Rst,
   mem_refill_arbiter_if.master bus
);
   localparam int IDX_W = $clog2(LINE_WORDS);
   localparam int OFF_W = IDX_W + 2;
   localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t            state_reg, state_next;
   logic              owner_reg, owner_next;            // 1 = D side
   logic              last_grant_reg, last_grant_next;  // 1 = D side
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic              ifill_reg, ifill_next;
   logic              dfill_reg, dfill_next;
   logic [IDX_W-1:0]  fill_idx_reg, fill_idx_next;
   logic [DATA_W-1:0] fill_data_reg, fill_data_next;
   logic              xfer_we;
   logic              grant_d;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_reg      <= IDLE;
         owner_reg      <= 1'b0;
         last_grant_reg <= 1'b0;
         idx_reg        <= '0;
         addr_reg       <= '0;
         ifill_reg      <= 1'b0;
         dfill_reg      <= 1'b0;
         fill_idx_reg   <= '0;
         fill_data_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_grant_reg <= last_grant_next;
         idx_reg        <= idx_next;
         addr_reg       <= addr_next;
         ifill_reg      <= ifill_next;
         dfill_reg      <= dfill_next;
         fill_idx_reg   <= fill_idx_next;
         fill_data_reg  <= fill_data_next;
      end
   end

   // On a tie the side that did not own the previous burst wins.
   assign grant_d = bus.i_DReq && (!bus.i_IReq || !last_grant_reg);
   assign xfer_we = (state_reg == XFER) && owner_reg && bus.i_DWe;

   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_grant_next = last_grant_reg;
      idx_next        = idx_reg;
      addr_next       = addr_reg;
      ifill_next      = 1'b0;
      dfill_next      = 1'b0;
      fill_idx_next   = fill_idx_reg;
      fill_data_next  = fill_data_reg;
      case (state_reg)
         IDLE: begin
            if (bus.i_IReq || bus.i_DReq) begin
               owner_next = grant_d;
               idx_next   = '0;
               addr_next  = (grant_d ? bus.i_DAddr : bus.i_IAddr) & LINE_MASK;
               state_next = XFER;
            end
         end
         XFER: begin
            if (bus.mem_ack) begin
               // idx wraps to 0 after the last word, ready for the next grant.
               idx_next  = idx_reg + IDX_W'(1);
               addr_next = addr_reg + ADDR_W'(4);
               if (!xfer_we) begin
                  ifill_next     = !owner_reg;
                  dfill_next     = owner_reg;
                  fill_idx_next  = idx_reg;
                  fill_data_next = bus.mem_rdata;
               end
               if (idx_reg == LAST_IDX) begin
                  state_next      = DONE;
                  last_grant_next = owner_reg;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign bus.mem_req      = (state_reg == XFER);
   assign bus.mem_we       = xfer_we;
   assign bus.mem_addr     = addr_reg;
   assign bus.mem_wdata    = xfer_we ? bus.i_DWData : '0;
   assign bus.o_IFillValid = ifill_reg;
   assign bus.o_DFillValid = dfill_reg;
   assign bus.o_FillIdx    = fill_idx_reg;
   assign bus.o_FillData   = fill_data_reg;
   assign bus.o_IDone      = (state_reg == DONE) && !owner_reg;
   assign bus.o_DDone      = (state_reg == DONE) && owner_reg;
   assign bus.o_IBusy      = bus.i_IReq || (!owner_reg && state_reg != IDLE);
   assign bus.o_DBusy      = bus.i_DReq || (owner_reg && state_reg != IDLE);
   assign bus.o_DWordIdx   = owner_reg ? idx_reg : '0;
endmodule
